// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encodings, state width and a width helper.
package rst_sequencer_pkg;

   localparam int unsigned StateW = 3;

   localparam logic [StateW-1:0] RSTSEQ_WAIT_LOCK   = 3'd0;
   localparam logic [StateW-1:0] RSTSEQ_LOCK_STABLE = 3'd1;
   localparam logic [StateW-1:0] RSTSEQ_WAIT_CAL    = 3'd2;
   localparam logic [StateW-1:0] RSTSEQ_REL_PERIPH  = 3'd3;
   localparam logic [StateW-1:0] RSTSEQ_RUN         = 3'd4;
   localparam logic [StateW-1:0] RSTSEQ_FAIL        = 3'd5;

   typedef enum logic [StateW-1:0] {
      StWaitLock   = RSTSEQ_WAIT_LOCK,
      StLockStable = RSTSEQ_LOCK_STABLE,
      StWaitCal    = RSTSEQ_WAIT_CAL,
      StRelPeriph  = RSTSEQ_REL_PERIPH,
      StRun        = RSTSEQ_RUN,
      StFail       = RSTSEQ_FAIL
   } seq_state_e;

   // Bits needed to hold the value v (at least one).
   function automatic int unsigned bits_for(input int unsigned v);
      return (v < 2) ? 1 : $clog2(v + 1);
   endfunction

endpackage

// File: rtl/rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; synchronous active-high reset to 0.
module rst_sequencer_sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for stable DCM/PLL lock, releases DDR2, then peripheral, then CPU resets,
// retrying DDR2 calibration on timeout. Optional CPU watchdog enabled by defining RSTSEQ_WDT_EN.
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned CAL_TIMEOUT_CYCLES = 1048576,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter int unsigned STAGE_GAP          = 16,
   parameter int unsigned WDT_CYCLES         = 65536
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       dcm_locked_i,
   input  logic       pll_locked_i,
   input  logic       ddr2_calib_done_i,
   input  logic       sw_rst_req_i,
   input  logic       wdt_kick_i,
   output logic       ddr2_rst_o,
   output logic       periph_rst_o,
   output logic       cpu_rst_o,
   output logic [2:0] seq_state_o,
   output logic [1:0] retry_cnt_o,
   output logic       seq_fail_o,
   output logic       wdt_bite_o
);

   localparam int unsigned MaxA  = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
   localparam int unsigned MaxT  = (MaxA > CAL_TIMEOUT_CYCLES) ? MaxA : CAL_TIMEOUT_CYCLES;
   localparam int unsigned CntW  = bits_for(MaxT - 1);

   localparam logic [CntW-1:0] LockTerm = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] CalTerm  = CntW'(CAL_TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] GapTerm  = CntW'(STAGE_GAP - 1);
   localparam logic [1:0]      RetryMax = 2'(MAX_RETRIES);

   logic dcm_sync, pll_sync, cal_sync, lock;

   seq_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]      retry_q, retry_d;
   logic            sw_hold_q, sw_hold_d;
   logic            bite_d;
   logic            ddr2_rst_q, ddr2_rst_d;
   logic            periph_rst_q, periph_rst_d;
   logic            cpu_rst_q, cpu_rst_d;
   logic            fail_q, fail_d;

   rst_sequencer_sync_2ff u_sync_dcm (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .d_i   (dcm_locked_i),
      .q_o   (dcm_sync)
   );

   rst_sequencer_sync_2ff u_sync_pll (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .d_i   (pll_locked_i),
      .q_o   (pll_sync)
   );

   rst_sequencer_sync_2ff u_sync_cal (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .d_i   (ddr2_calib_done_i),
      .q_o   (cal_sync)
   );

   assign lock = dcm_sync & pll_sync;

`ifdef RSTSEQ_WDT_EN
   localparam int unsigned     WdtW    = bits_for(WDT_CYCLES - 1);
   localparam logic [WdtW-1:0] WdtTerm = WdtW'(WDT_CYCLES - 1);

   logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
   logic            bite_q;

   // Watchdog counter and bite pulse register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wdt_cnt_q <= '0;
         bite_q    <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         bite_q    <= bite_d;
      end
   end

   assign wdt_bite_o = bite_q;
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick_i | (WDT_CYCLES == 0) | bite_d;
   assign wdt_bite_o = 1'b0;
`endif

   // Next-state, counters and registered-output decode of the next state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      retry_d   = retry_q;
      sw_hold_d = 1'b0;
      bite_d    = 1'b0;
      cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
`ifdef RSTSEQ_WDT_EN
      wdt_cnt_d = '0;
`endif
      case (state_q)
         StWaitLock: begin
            if (lock) state_d = StLockStable;
         end
         StLockStable: begin
            if (!lock)                state_d = StWaitLock;
            else if (cnt_q == LockTerm) state_d = StWaitCal;
            else                      cnt_d = cnt_inc;
         end
         StWaitCal: begin
            if (!lock) begin
               state_d = StWaitLock;
            end else if (cal_sync) begin
               state_d = StRelPeriph;
            end else if (cnt_q == CalTerm) begin
               if (retry_q < RetryMax) begin
                  retry_d = retry_q + 2'd1;
                  state_d = StWaitLock;
               end else begin
                  state_d = StFail;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StRelPeriph: begin
            // After a soft reset, hold one cycle with periph in reset, then restart the gap.
            if (!lock)                 state_d = StWaitLock;
            else if (sw_hold_q)        state_d = StRelPeriph;
            else if (cnt_q == GapTerm) state_d = StRun;
            else                       cnt_d = cnt_inc;
         end
         StRun: begin
            if (!lock) begin
               state_d = StWaitLock;
            end else if (sw_rst_req_i) begin
               state_d   = StRelPeriph;
               sw_hold_d = 1'b1;
            end
`ifdef RSTSEQ_WDT_EN
            else if (wdt_kick_i) begin
               wdt_cnt_d = '0;
            end else if (wdt_cnt_q == WdtTerm) begin
               bite_d  = 1'b1;
               state_d = StRelPeriph;
            end else begin
               wdt_cnt_d = (wdt_cnt_q == '1) ? wdt_cnt_q : wdt_cnt_q + WdtW'(1);
            end
`endif
         end
         StFail: begin
            state_d = StFail;
         end
         default: begin
            state_d = StWaitLock;
         end
      endcase

      ddr2_rst_d   = (state_d != StWaitCal) && (state_d != StRelPeriph) && (state_d != StRun);
      periph_rst_d = !(((state_d == StRelPeriph) && !sw_hold_d) || (state_d == StRun));
      cpu_rst_d    = (state_d != StRun);
      fail_d       = (state_d == StFail);
   end

   // State, counters and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= StWaitLock;
         cnt_q        <= '0;
         retry_q      <= 2'd0;
         sw_hold_q    <= 1'b0;
         ddr2_rst_q   <= 1'b1;
         periph_rst_q <= 1'b1;
         cpu_rst_q    <= 1'b1;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         sw_hold_q    <= sw_hold_d;
         ddr2_rst_q   <= ddr2_rst_d;
         periph_rst_q <= periph_rst_d;
         cpu_rst_q    <= cpu_rst_d;
         fail_q       <= fail_d;
      end
   end

   assign ddr2_rst_o   = ddr2_rst_q;
   assign periph_rst_o = periph_rst_q;
   assign cpu_rst_o    = cpu_rst_q;
   assign seq_state_o  = state_q;
   assign retry_cnt_o  = retry_q;
   assign seq_fail_o   = fail_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with small timing parameters; honours RSTSEQ_WDT_EN.
module tb_rst_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dcm = 1'b0;
   logic       pll = 1'b0;
   logic       cal = 1'b0;
   logic       sw = 1'b0;
   logic       kick = 1'b0;
   logic       ddr2_rst, periph_rst, cpu_rst, seq_fail, wdt_bite;
   logic [2:0] seq_state;
   logic [1:0] retry_cnt;

   int checks = 0;
   int errors = 0;

   rst_sequencer #(
      .LOCK_STABLE_CYCLES (8),
      .CAL_TIMEOUT_CYCLES (32),
      .MAX_RETRIES        (2),
      .STAGE_GAP          (4),
      .WDT_CYCLES         (64)
   ) dut (
      .wb_clk_i          (clk),
      .wb_rst_i          (rst),
      .dcm_locked_i      (dcm),
      .pll_locked_i      (pll),
      .ddr2_calib_done_i (cal),
      .sw_rst_req_i      (sw),
      .wdt_kick_i        (kick),
      .ddr2_rst_o        (ddr2_rst),
      .periph_rst_o      (periph_rst),
      .cpu_rst_o         (cpu_rst),
      .seq_state_o       (seq_state),
      .retry_cnt_o       (retry_cnt),
      .seq_fail_o        (seq_fail),
      .wdt_bite_o        (wdt_bite)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick(2);
      chk("rst_state", 32'(seq_state), 0);
      chk("rst_ddr2", 32'(ddr2_rst), 1);
      chk("rst_periph", 32'(periph_rst), 1);
      chk("rst_cpu", 32'(cpu_rst), 1);
      chk("rst_retry", 32'(retry_cnt), 0);
      chk("rst_fail", 32'(seq_fail), 0);
      chk("rst_bite", 32'(wdt_bite), 0);
      rst = 1'b0;
      tick(1);

      // Normal bring-up: locks rise after edge E0
      dcm = 1'b1;
      pll = 1'b1;
      tick(2);
      chk("norm_e2_state", 32'(seq_state), 0);
      tick(1);
      chk("norm_e3_state", 32'(seq_state), 1);
      tick(7);
      chk("norm_e10_state", 32'(seq_state), 1);
      chk("norm_e10_ddr2", 32'(ddr2_rst), 1);
      tick(1);
      chk("norm_e11_state", 32'(seq_state), 2);
      chk("norm_e11_ddr2", 32'(ddr2_rst), 0);
      chk("norm_e11_periph", 32'(periph_rst), 1);
      tick(9);
      cal = 1'b1;
      tick(2);
      chk("norm_cal2_state", 32'(seq_state), 2);
      chk("norm_cal2_periph", 32'(periph_rst), 1);
      tick(1);
      chk("norm_cal3_state", 32'(seq_state), 3);
      chk("norm_cal3_periph", 32'(periph_rst), 0);
      chk("norm_cal3_cpu", 32'(cpu_rst), 1);
      tick(3);
      chk("norm_gap3_cpu", 32'(cpu_rst), 1);
      tick(1);
      chk("norm_run_state", 32'(seq_state), 4);
      chk("norm_run_cpu", 32'(cpu_rst), 0);
      chk("norm_run_ddr2", 32'(ddr2_rst), 0);
      chk("norm_run_retry", 32'(retry_cnt), 0);

      // Soft reset in RUN; a second request during REL_PERIPH is ignored
      tick(2);
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      chk("sw_state", 32'(seq_state), 3);
      chk("sw_periph", 32'(periph_rst), 1);
      chk("sw_cpu", 32'(cpu_rst), 1);
      chk("sw_ddr2", 32'(ddr2_rst), 0);
      tick(1);
      chk("sw_rel_periph", 32'(periph_rst), 0);
      chk("sw_rel_cpu", 32'(cpu_rst), 1);
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      chk("sw_ign_periph", 32'(periph_rst), 0);
      tick(2);
      chk("sw_gap_cpu", 32'(cpu_rst), 1);
      tick(1);
      chk("sw_run_cpu", 32'(cpu_rst), 0);
      chk("sw_run_state", 32'(seq_state), 4);
      chk("sw_run_ddr2", 32'(ddr2_rst), 0);

`ifdef RSTSEQ_WDT_EN
      // Watchdog: bite after 64 unkicked RUN cycles
      tick(63);
      chk("wdt_pre_bite", 32'(wdt_bite), 0);
      chk("wdt_pre_cpu", 32'(cpu_rst), 0);
      tick(1);
      chk("wdt_bite", 32'(wdt_bite), 1);
      chk("wdt_bite_cpu", 32'(cpu_rst), 1);
      chk("wdt_bite_periph", 32'(periph_rst), 0);
      chk("wdt_bite_state", 32'(seq_state), 3);
      tick(1);
      chk("wdt_pulse_end", 32'(wdt_bite), 0);
      tick(2);
      chk("wdt_gap_cpu", 32'(cpu_rst), 1);
      tick(1);
      chk("wdt_run_cpu", 32'(cpu_rst), 0);
      // Kick in the expiry cycle wins, then the window restarts
      tick(63);
      kick = 1'b1;
      tick(1);
      kick = 1'b0;
      chk("wdt_kick_bite", 32'(wdt_bite), 0);
      chk("wdt_kick_cpu", 32'(cpu_rst), 0);
      tick(63);
      chk("wdt_rewin_bite0", 32'(wdt_bite), 0);
      tick(1);
      chk("wdt_rewin_bite1", 32'(wdt_bite), 1);
      tick(4);
      chk("wdt_rewin_run", 32'(seq_state), 4);
`else
      // No watchdog: RUN holds indefinitely without kicks
      tick(70);
      chk("nowdt_bite", 32'(wdt_bite), 0);
      chk("nowdt_cpu", 32'(cpu_rst), 0);
      chk("nowdt_state", 32'(seq_state), 4);
`endif

      // Lock loss in RUN
      dcm = 1'b0;
      cal = 1'b0;
      tick(2);
      chk("loss_e2_state", 32'(seq_state), 4);
      tick(1);
      chk("loss_state", 32'(seq_state), 0);
      chk("loss_ddr2", 32'(ddr2_rst), 1);
      chk("loss_periph", 32'(periph_rst), 1);
      chk("loss_cpu", 32'(cpu_rst), 1);
      chk("loss_retry", 32'(retry_cnt), 0);

      // Glitch: pll low for one cycle at LOCK_STABLE count 5
      dcm = 1'b1;
      tick(8);
      pll = 1'b0;
      tick(1);
      pll = 1'b1;
      tick(1);
      chk("glitch_pre_state", 32'(seq_state), 1);
      tick(1);
      chk("glitch_drop_state", 32'(seq_state), 0);
      tick(1);
      chk("glitch_relock_state", 32'(seq_state), 1);
      tick(7);
      chk("glitch_full_state", 32'(seq_state), 1);
      chk("glitch_full_ddr2", 32'(ddr2_rst), 1);
      tick(1);
      chk("glitch_cal_state", 32'(seq_state), 2);
      chk("glitch_cal_ddr2", 32'(ddr2_rst), 0);

      // Retry: calibration never completes
      tick(31);
      chk("retry0_state", 32'(seq_state), 2);
      chk("retry0_cnt", 32'(retry_cnt), 0);
      tick(1);
      chk("retry1_state", 32'(seq_state), 0);
      chk("retry1_cnt", 32'(retry_cnt), 1);
      chk("retry1_ddr2", 32'(ddr2_rst), 1);
      tick(9);
      chk("retry1_cal_state", 32'(seq_state), 2);
      tick(32);
      chk("retry2_state", 32'(seq_state), 0);
      chk("retry2_cnt", 32'(retry_cnt), 2);
      tick(9);
      chk("retry2_cal_state", 32'(seq_state), 2);
      tick(31);
      chk("retry2_pre_fail", 32'(seq_fail), 0);
      tick(1);
      chk("fail_state", 32'(seq_state), 5);
      chk("fail_flag", 32'(seq_fail), 1);
      chk("fail_ddr2", 32'(ddr2_rst), 1);
      chk("fail_periph", 32'(periph_rst), 1);
      chk("fail_cpu", 32'(cpu_rst), 1);
      chk("fail_retry", 32'(retry_cnt), 2);
      cal = 1'b1;
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      tick(10);
      chk("fail_sticky_state", 32'(seq_state), 5);
      chk("fail_sticky_flag", 32'(seq_fail), 1);

      // Only wb_rst_i leaves FAIL
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rerst_state", 32'(seq_state), 0);
      chk("rerst_fail", 32'(seq_fail), 0);
      chk("rerst_retry", 32'(retry_cnt), 0);
      chk("rerst_ddr2", 32'(ddr2_rst), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
